pong_match_controller: RTL and testbench
========================================

# pong_match_controller

Match-sequencing FSM for the Pong game. It sits between the VGA frame timing (`frame_done`), the synchronized start button and the ball/paddle datapath. It decides when the ball is served, when play is live, how points are scored and when a match ends. It owns the score registers that feed the seven-segment displays.

## Interface
Parameters:
- `WIN_POINTS`, 7: score that ends the match; legal range 1..15.
- `SERVE_FRAMES`, 60: frames between entering serve and ball launch; legal range 1..255.
- `PAUSE_FRAMES`, 90: frames of freeze after a point; legal range 1..255.

Ports:
- `clock`  in  1  pixel clock, 40 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `frame_done`  in  1  one-cycle pulse per frame, from vga.
- `start_pt`  in  1  synchronized start button, level.
- `miss_left`  in  1  one-cycle pulse: ball passed the P1 (left) edge.
- `miss_right`  in  1  one-cycle pulse: ball passed the P2 (right) edge.
- `ball_launch`  out  1  one-cycle pulse: datapath re-centres the ball and starts it moving.
- `serve_dir`  out  1  launch direction; 0 = toward P1, 1 = toward P2.
- `play_en`  out  1  ball/paddle motion enable.
- `p1_points`  out  4  P1 score.
- `p2_points`  out  4  P2 score.
- `winner`  out  2  00 none, 01 P1, 10 P2.
- `state`  out  3  current FSM state, for debug.

## Operation
The block detects the rising edge of `start_pt` with a registered previous value. A rising edge is acted on only in IDLE and GAME_OVER; in every other state it is ignored.

States and transitions:
- **IDLE** (reset state):
  - scores are 0 and `play_en`=0;
  - a start edge moves to SERVE_WAIT.
- **SERVE_WAIT**:
  - the frame counter counts `frame_done` pulses;
  - on the `SERVE_FRAMES`-th pulse the FSM moves to PLAY.
- **PLAY**:
  - `play_en`=1;
  - `ball_launch`=1 in the first PLAY cycle only.
- **Scoring in PLAY**:
  - `miss_left` alone: `p2_points`+1 and `serve_dir`←0.
  - `miss_right` alone: `p1_points`+1 and `serve_dir`←1.
  - Both in the same cycle: no score change and `serve_dir` unchanged. This counts as a dead ball and goes to POINT_PAUSE.
  - If the incremented score equals `WIN_POINTS`, the FSM goes to GAME_OVER and `winner` is set. Otherwise it goes to POINT_PAUSE.
- **POINT_PAUSE**:
  - `play_en`=0;
  - after `PAUSE_FRAMES` `frame_done` pulses the FSM moves to SERVE_WAIT.
- **GAME_OVER**:
  - `play_en`=0; scores and `winner` are held;
  - a start edge clears the scores and `winner`, sets `serve_dir`←1 and moves to SERVE_WAIT.

Other rules:
- `miss_left`/`miss_right` outside PLAY are ignored.
- Scores never exceed `WIN_POINTS`; no wrap is possible.
- The frame counter is `$clog2(256)`=8 bits wide. It is cleared on every state entry.
- A `frame_done` pulse in the same cycle as a state transition is not counted toward the new state's count.

## Timing
- All outputs are registered.
- Reset values: `state`=IDLE(0), `play_en`=0, `ball_launch`=0, `serve_dir`=1, scores=0, `winner`=00.
- Assertion of `reset_n` takes effect immediately, including mid-rally or mid-pause. Release is synchronous to `clock`.
- Input-to-state latency is 1 cycle. A start edge sampled in cycle n makes `state`=SERVE_WAIT in n+1.
- A miss sampled in cycle n updates the score, `serve_dir` and `state` in n+1. `play_en` falls in n+1.
- `ball_launch` is high in exactly the cycle in which `state` first reads PLAY. `play_en` rises in the same cycle.
- SERVE_WAIT lasts exactly `SERVE_FRAMES` counted `frame_done` pulses plus 1 cycle. POINT_PAUSE follows the same rule with `PAUSE_FRAMES`.

## Structure
- `pong_pkg` holds:
  - `typedef enum logic [2:0] match_state_t` with values IDLE=0, SERVE_WAIT=1, PLAY=2, POINT_PAUSE=3, GAME_OVER=4;
  - the default constants for `WIN_POINTS`, `SERVE_FRAMES` and `PAUSE_FRAMES`.
- The block contains one sub-module, `frame_timer`. It counts `frame_done` pulses and has inputs `clear` and `target[7:0]` and an output `expired`, a one-cycle pulse. The controller instantiates it once and reloads it on state entry.
- The FSM uses a two-process style: a registered state and a combinational next-state.

## Test plan
- **Reset, then start:** release `reset_n`, pulse `start_pt`, send 60 `frame_done` pulses → `state` reads 1 and then 2; `ball_launch` is high for exactly one cycle; `play_en`=1.
- **Point for P2:** in PLAY, pulse `miss_left` → next cycle `p2_points`=1, `serve_dir`=0, `state`=3. After 90 frames → `state`=1.
- **Simultaneous misses:** in PLAY, pulse `miss_left` and `miss_right` in the same cycle → scores unchanged, `serve_dir` unchanged, `state`=3.
- **Match win:** P1 scores 7 with `WIN_POINTS`=7 → `state`=4, `winner`=01, `p1_points`=7 held. Extra `miss_right` and `frame_done` pulses cause no change.
- **Rematch:** from GAME_OVER, hold `start_pt` high for 10 cycles → one transition only. Scores become 0, `winner`=00, `serve_dir`=1, `state`=1.
- **Reset mid-pause:** assert `reset_n` low during POINT_PAUSE with frame count 40 → all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and default constants for the Pong match controller.
// State encodings are visible on the debug port, so their values are fixed.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SERVE_WAIT  = 3'd1,
    PLAY        = 3'd2,
    POINT_PAUSE = 3'd3,
    GAME_OVER   = 3'd4
  } match_state_t;

  localparam int unsigned DEFAULT_WIN_POINTS   = 7;
  localparam int unsigned DEFAULT_SERVE_FRAMES = 60;
  localparam int unsigned DEFAULT_PAUSE_FRAMES = 90;
  localparam int unsigned FRAME_CNT_W          = $clog2(256);

endpackage

// File: rtl/pong_match_controller_frame_timer.sv
// Counts frame_done pulses; expired pulses combinationally on the pulse that
// reaches target so the owning FSM can change state on that same edge.
module frame_timer
  import pong_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   frame_done,
  input  logic [FRAME_CNT_W-1:0] target,
  output logic                   expired
);

  logic [FRAME_CNT_W-1:0] count_q, count_d;

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    expired = 1'b0;
    if (frame_done && ({1'b0, count_q} + 9'd1 == {1'b0, target})) begin
      expired = 1'b1;
    end
    if (clear) begin
      count_d = '0;
    end else if (frame_done) begin
      count_d = count_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pong_match_controller.sv
// Match-sequencing FSM for Pong: serve delay, live play, scoring, pause and
// game over. All outputs come straight from flops.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int unsigned WIN_POINTS   = DEFAULT_WIN_POINTS,
  parameter int unsigned SERVE_FRAMES = DEFAULT_SERVE_FRAMES,
  parameter int unsigned PAUSE_FRAMES = DEFAULT_PAUSE_FRAMES
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       frame_done,
  input  logic       start_pt,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_launch,
  output logic       serve_dir,
  output logic       play_en,
  output logic [3:0] p1_points,
  output logic [3:0] p2_points,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [3:0]             WIN_PTS = 4'(WIN_POINTS);
  localparam logic [FRAME_CNT_W-1:0] SERVE_T = FRAME_CNT_W'(SERVE_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] PAUSE_T = FRAME_CNT_W'(PAUSE_FRAMES);

  match_state_t state_q, state_d;
  logic         start_prev_q;
  logic [3:0]   p1_q, p1_d, p2_q, p2_d;
  logic [1:0]   winner_q, winner_d;
  logic         serve_dir_q, serve_dir_d;
  logic         play_en_q, play_en_d;
  logic         ball_launch_q, ball_launch_d;

  logic                   start_edge;
  logic                   timed_state;
  logic                   timer_clear;
  logic                   timer_expired;
  logic [FRAME_CNT_W-1:0] timer_target;

  assign start_edge   = start_pt && !start_prev_q;
  assign timed_state  = (state_q == SERVE_WAIT) || (state_q == POINT_PAUSE);
  assign timer_target = (state_q == POINT_PAUSE) ? PAUSE_T : SERVE_T;
  // Timed states are only ever left via expiry and only ever entered from
  // untimed states or via expiry, so this clears the count on every entry.
  assign timer_clear  = !timed_state || timer_expired;

  frame_timer u_frame_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (timer_clear),
    .frame_done (frame_done),
    .target     (timer_target),
    .expired    (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    winner_d    = winner_q;
    serve_dir_d = serve_dir_q;
    unique case (state_q)
      IDLE: if (start_edge) state_d = SERVE_WAIT;
      SERVE_WAIT: if (timer_expired) state_d = PLAY;
      PLAY: begin
        if (miss_left && miss_right) begin
          state_d = POINT_PAUSE;
        end else if (miss_left) begin
          p2_d        = p2_q + 4'd1;
          serve_dir_d = 1'b0;
          if (p2_d == WIN_PTS) begin
            winner_d = 2'b10;
            state_d  = GAME_OVER;
          end else begin
            state_d = POINT_PAUSE;
          end
        end else if (miss_right) begin
          p1_d        = p1_q + 4'd1;
          serve_dir_d = 1'b1;
          if (p1_d == WIN_PTS) begin
            winner_d = 2'b01;
            state_d  = GAME_OVER;
          end else begin
            state_d = POINT_PAUSE;
          end
        end
      end
      POINT_PAUSE: if (timer_expired) state_d = SERVE_WAIT;
      GAME_OVER: begin
        if (start_edge) begin
          p1_d        = '0;
          p2_d        = '0;
          winner_d    = 2'b00;
          serve_dir_d = 1'b1;
          state_d     = SERVE_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    play_en_d     = (state_d == PLAY);
    ball_launch_d = (state_d == PLAY) && (state_q != PLAY);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      start_prev_q  <= 1'b0;
      p1_q          <= '0;
      p2_q          <= '0;
      winner_q      <= 2'b00;
      serve_dir_q   <= 1'b1;
      play_en_q     <= 1'b0;
      ball_launch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= start_pt;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      winner_q      <= winner_d;
      serve_dir_q   <= serve_dir_d;
      play_en_q     <= play_en_d;
      ball_launch_q <= ball_launch_d;
    end
  end

  assign state       = state_q;
  assign p1_points   = p1_q;
  assign p2_points   = p2_q;
  assign winner      = winner_q;
  assign serve_dir   = serve_dir_q;
  assign play_en     = play_en_q;
  assign ball_launch = ball_launch_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed scenarios plus a randomized run against a rule-level match model.
module tb_pong_match_controller;

  localparam int WIN   = 7;
  localparam int SERVE = 60;
  localparam int PAUSE = 90;

  logic       clock, reset_n;
  logic       frame_done, start_pt, miss_left, miss_right;
  logic       ball_launch, serve_dir, play_en;
  logic [3:0] p1_points, p2_points;
  logic [1:0] winner;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: match phase, pulses seen in that phase, score tally.
  int m_state, m_frames, m_p1, m_p2, m_winner;
  bit m_dir, m_launch, m_play, m_start_prev;

  pong_match_controller #(
    .WIN_POINTS   (WIN),
    .SERVE_FRAMES (SERVE),
    .PAUSE_FRAMES (PAUSE)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .frame_done  (frame_done),
    .start_pt    (start_pt),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .ball_launch (ball_launch),
    .serve_dir   (serve_dir),
    .play_en     (play_en),
    .p1_points   (p1_points),
    .p2_points   (p2_points),
    .winner      (winner),
    .state       (state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic model_reset();
    m_state = 0; m_frames = 0; m_p1 = 0; m_p2 = 0; m_winner = 0;
    m_dir = 1'b1; m_launch = 1'b0; m_play = 1'b0; m_start_prev = 1'b0;
  endtask

  task automatic model_update(input bit fd, input bit st, input bit ml, input bit mr);
    int prev;
    bit rise;
    prev = m_state;
    rise = st && !m_start_prev;
    m_start_prev = st;
    case (m_state)
      0: if (rise) m_state = 1;
      1: if (fd) begin
           m_frames++;
           if (m_frames == SERVE) m_state = 2;
         end
      2: if (ml && mr) m_state = 3;
         else if (ml) begin
           m_p2++; m_dir = 1'b0;
           if (m_p2 == WIN) begin m_winner = 2; m_state = 4; end else m_state = 3;
         end else if (mr) begin
           m_p1++; m_dir = 1'b1;
           if (m_p1 == WIN) begin m_winner = 1; m_state = 4; end else m_state = 3;
         end
      3: if (fd) begin
           m_frames++;
           if (m_frames == PAUSE) m_state = 1;
         end
      default: if (rise) begin
           m_p1 = 0; m_p2 = 0; m_winner = 0; m_dir = 1'b1; m_state = 1;
         end
    endcase
    if (m_state != prev) m_frames = 0;
    m_play   = (m_state == 2);
    m_launch = (m_state == 2) && (prev != 2);
  endtask

  // Drives one cycle of inputs from a falling edge and returns at the next falling edge.
  task automatic step(input bit fd, input bit st, input bit ml, input bit mr);
    frame_done = fd; start_pt = st; miss_left = ml; miss_right = mr;
    @(posedge clock);
    model_update(fd, st, ml, mr);
    @(negedge clock);
  endtask

  task automatic send_frames(input int n);
    repeat (n) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic reset_dut();
    frame_done = 1'b0; start_pt = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    frame_done = 1'b0; start_pt = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (play_en !== 1'b0 || ball_launch !== 1'b0) begin errors++; $display("FAIL reset_play got %b%b want 00", play_en, ball_launch); end
    checks++; if (serve_dir !== 1'b1) begin errors++; $display("FAIL reset_dir got %b want 1", serve_dir); end
    checks++; if (p1_points !== 4'd0 || p2_points !== 4'd0 || winner !== 2'b00) begin
      errors++; $display("FAIL reset_score got %0d/%0d/%0d want 0/0/0", p1_points, p2_points, winner);
    end
    reset_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_hold got %0d want 0", state); end
  endtask

  task automatic test_start_serve();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL start_edge got %0d want 1", state); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_frames(SERVE - 1);
    checks++; if (state !== 3'd1 || play_en !== 1'b0) begin errors++; $display("FAIL serve_early got %0d/%b want 1/0", state, play_en); end
    send_frames(1);
    checks++; if (state !== 3'd2 || ball_launch !== 1'b1 || play_en !== 1'b1) begin
      errors++; $display("FAIL launch got %0d/%b/%b want 2/1/1", state, ball_launch, play_en);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (ball_launch !== 1'b0 || play_en !== 1'b1) begin errors++; $display("FAIL launch_once got %b/%b want 0/1", ball_launch, play_en); end
  endtask

  task automatic test_point_p2();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (p2_points !== 4'd1 || p1_points !== 4'd0 || serve_dir !== 1'b0) begin
      errors++; $display("FAIL p2_point got %0d/%0d/%b want 0/1/0", p1_points, p2_points, serve_dir);
    end
    checks++; if (state !== 3'd3 || play_en !== 1'b0) begin errors++; $display("FAIL p2_pause got %0d/%b want 3/0", state, play_en); end
    send_frames(PAUSE - 1);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL pause_early got %0d want 3", state); end
    send_frames(1);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL pause_done got %0d want 1", state); end
  endtask

  task automatic test_dead_ball();
    send_frames(SERVE);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (state !== 3'd3 || p1_points !== 4'd0 || p2_points !== 4'd1 || serve_dir !== 1'b0) begin
      errors++; $display("FAIL dead_ball got %0d/%0d/%0d/%b want 3/0/1/0", state, p1_points, p2_points, serve_dir);
    end
    send_frames(PAUSE);
  endtask

  task automatic test_match_win();
    reset_dut();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= WIN; k++) begin
      send_frames(SERVE);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (k < WIN) begin
        checks++; if (state !== 3'd3 || p1_points !== 4'(k)) begin
          errors++; $display("FAIL p1_point_%0d got %0d/%0d want 3/%0d", k, state, p1_points, k);
        end
        send_frames(PAUSE);
      end
    end
    checks++; if (state !== 3'd4 || winner !== 2'b01 || p1_points !== 4'd7 || play_en !== 1'b0) begin
      errors++; $display("FAIL win got %0d/%0d/%0d/%b want 4/1/7/0", state, winner, p1_points, play_en);
    end
    repeat (5) step(1'b1, 1'b0, 1'b1, 1'b1);
    checks++; if (state !== 3'd4 || winner !== 2'b01 || p1_points !== 4'd7 || p2_points !== 4'd0) begin
      errors++; $display("FAIL win_hold got %0d/%0d/%0d/%0d want 4/1/7/0", state, winner, p1_points, p2_points);
    end
  endtask

  task automatic test_rematch();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (state !== 3'd1 || p1_points !== 4'd0 || p2_points !== 4'd0 || winner !== 2'b00 || serve_dir !== 1'b1) begin
      errors++; $display("FAIL rematch got %0d/%0d/%0d/%0d/%b want 1/0/0/0/1", state, p1_points, p2_points, winner, serve_dir);
    end
    repeat (9) step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL rematch_hold got %0d want 1", state); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_frames(SERVE - 1);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL rematch_serve got %0d want 1", state); end
    send_frames(1);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL rematch_play got %0d want 2", state); end
  endtask

  task automatic test_reset_mid_pause();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_frames(40);
    checks++; if (state !== 3'd3 || p2_points !== 4'd1) begin errors++; $display("FAIL mid_pause got %0d/%0d want 3/1", state, p2_points); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || play_en !== 1'b0 || ball_launch !== 1'b0 || serve_dir !== 1'b1 ||
                  p1_points !== 4'd0 || p2_points !== 4'd0 || winner !== 2'b00) begin
      errors++; $display("FAIL async_reset got %0d/%b/%b/%b/%0d/%0d/%0d want 0/0/0/1/0/0/0",
                         state, play_en, ball_launch, serve_dir, p1_points, p2_points, winner);
    end
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    bit st_level;
    logic [15:0] got, want;
    st_level = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 39) == 0) st_level = ~st_level;
      step(1'($urandom_range(0, 1)), st_level,
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
      got  = {state, play_en, ball_launch, serve_dir, p1_points, p2_points, winner};
      want = {3'(m_state), m_play, m_launch, m_dir, 4'(m_p1), 4'(m_p2), 2'(m_winner)};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL random_cycle_%0d got %h want %h", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_serve();
    test_point_p2();
    test_dead_ball();
    test_match_win();
    test_rematch();
    test_reset_mid_pause();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
